commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Synthesizable retire monitor placed alongside top_parts, fed by its fetch-side pc/inst outputs.
- Detects each new pc and aligns it to writeback through a (DELAY+1)-entry history shift line.
- Emits one commit record per retired instruction into a first-word-fall-through (FWFT) FIFO, drained by a debug/UART reader through a valid/read handshake.
- Stops recording after MAX_COUNT commits, mirroring the simulation trace limit in hardware.

Parameters:
- DELAY, 4, index of history entry treated as retired (history has DELAY+1 entries); legal 1..8
- FIFO_DEPTH, 16, commit FIFO entries; power of two, 2..256
- MAX_COUNT, 5000, commits recorded before done asserts; must be < 65536

Ports:
- clk  in  1  posedge clock
- reset  in  1  synchronous, active-high
- pc  in  32  current fetch pc from core
- inst  in  32  instruction paired with pc
- cpu_stall  in  1  1 = freeze capture this cycle
- rd_en  in  1  pop request from reader
- rd_valid  out  1  FIFO head valid
- rd_pc  out  32  head record pc
- rd_inst  out  32  head record instruction
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- commit_count  out  16  commits recognised since reset
- overflow  out  1  sticky; a commit was dropped because the FIFO was full
- done  out  1  commit_count reached MAX_COUNT

Behaviour:
- Reset (synchronous, active-high, clk rising edge) clears:
  - last_pc, all hist_pc[i] and hist_inst[i], FIFO pointers and contents, commit_count, fifo_count, rd_valid, overflow, done.
  - rd_pc/rd_inst = 0.
- Reset asserted mid-operation discards all queued records on the next edge.
- Capture condition, evaluated each edge: !reset && !cpu_stall && !done && (pc != last_pc).
- On capture:
  - last_pc <= pc.
  - hist[0] <= {pc, inst}; hist[i] <= hist[i-1] for i = 1..DELAY.
- Commit, same edge as capture: if the old hist_pc[DELAY-1] (the value shifting into hist[DELAY]) != 0:
  - push {old hist_pc[DELAY-1], old hist_inst[DELAY-1]};
  - commit_count += 1.
- pc == 0 entries are bubbles: shifted through but never committed.
- pc equal to last_pc (a repeated pc) produces no shift and no commit. Initial last_pc = 0, so pc 0 held after reset produces nothing.
- Latency: a record appears at the FIFO head (rd_valid = 1) one cycle after its commit edge, when the FIFO was empty.
- The first commit occurs on the (DELAY+1)-th distinct nonzero pc after reset.
- done:
  - Asserts on the edge where commit_count becomes MAX_COUNT.
  - Stays high until reset.
  - While done = 1: capture and commit are frozen; FIFO draining continues.
- FIFO is FWFT: rd_pc/rd_inst are valid whenever rd_valid = 1.
  - Pop when rd_en && rd_valid. rd_en with FIFO empty is ignored.
  - Push when FIFO full and no pop in the same cycle: record dropped, overflow <= 1, commit_count still increments.
  - Simultaneous push and pop when full: both take effect, no overflow, fifo_count unchanged.
  - Simultaneous push and pop when empty: the push is accepted and rd_valid = 1 next cycle; the pop is ignored.
- fifo_count is updated registered, same edge as push/pop, and never exceeds FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: TRACE_SKIP_NOP_EN.
- Defined: a commit whose instruction == 32'h00000000 is neither pushed nor counted; history shifting is unchanged.
- Undefined: all-zero instructions commit like any other.

Test Plan:
- Basic alignment: DELAY=4, one pc per cycle 0x00400000, 0x00400004, ... 0x00400014 with inst = pc ^ 0xA5A5A5A5.
  -> First push on the 5th capture (pc 0x00400010) holds rd_pc = 0x00400000.
  -> After 6 captures: fifo_count = 2, commit_count = 2.
- Stall/repeat: hold pc 0x00400008 for 3 cycles, then assert cpu_stall for 2 cycles while pc changes.
  -> No shifts, commit_count unchanged; capture resumes the first cycle cpu_stall = 0.
- Overflow: FIFO_DEPTH=16, rd_en = 0, 20 commits.
  -> fifo_count = 16, overflow = 1, commit_count = 20, head rd_pc = first committed pc.
  -> A simultaneous push+pop when full leaves fifo_count = 16.
- Done limit: MAX_COUNT=8, 12 distinct pcs after warm-up.
  -> done = 1 on the 8th commit, commit_count stays 8, FIFO drains 8 records in order.
- Mid-operation reset: reset for 1 cycle with fifo_count = 5.
  -> Next cycle: rd_valid = 0, fifo_count = 0, commit_count = 0, overflow = 0; the next commit needs 5 new distinct pcs.
- TRACE_SKIP_NOP_EN defined: the stream includes inst 0x00000000 at the pc that reaches hist[4].
  -> That record is absent from the FIFO and commit_count is one lower than in the undefined build.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Retire monitor that sits beside the core and watches its fetch-side pc/inst.
// Each new pc is shifted into a history line. The entry that ages past
// position DELAY-1 is treated as retired and is queued as a commit record in a
// first-word-fall-through FIFO, which a debug reader drains with rd_en.
// Recording stops once MAX_COUNT commits have been seen.
//
// Optional build macro: TRACE_SKIP_NOP_EN
//   When defined, a retiring instruction that is all zeros is neither queued
//   nor counted. The history shift is not affected.

module commit_trace_buffer #(
   parameter int DELAY      = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_COUNT  = 5000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   pc,
   input  logic [31:0]                   inst,
   input  logic                          cpu_stall,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [31:0]                   rd_pc,
   output logic [31:0]                   rd_inst,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   commit_count,
   output logic                          overflow,
   output logic                          done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      LAST_COUNT = 16'(MAX_COUNT - 1);

   // Fetch-side tracking and history line (entry 0 is the newest capture)
   logic [31:0] last_pc;
   logic [31:0] hist_pc   [0:DELAY];
   logic [31:0] hist_inst [0:DELAY];

   // Commit FIFO storage and bookkeeping
   logic [31:0]      mem_pc   [0:FIFO_DEPTH-1];
   logic [31:0]      mem_inst [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // Per-cycle decisions
   logic        capture;
   logic [31:0] retire_pc;
   logic [31:0] retire_inst;
   logic        commit;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        push;
   logic        drop;

   // Decide whether this edge captures a new pc, retires a record, and how the FIFO moves
   always_comb begin
      capture     = 1'b0;
      retire_pc   = hist_pc[DELAY-1];
      retire_inst = hist_inst[DELAY-1];
      commit      = 1'b0;
      fifo_full   = 1'b0;
      fifo_empty  = 1'b0;
      pop         = 1'b0;
      push        = 1'b0;
      drop        = 1'b0;

      capture = !cpu_stall && !done && (pc != last_pc);

`ifdef TRACE_SKIP_NOP_EN
      commit = capture && (retire_pc != 32'd0) && (retire_inst != 32'd0);
`else
      commit = capture && (retire_pc != 32'd0);
`endif

      fifo_full  = (count == FULL_LEVEL);
      fifo_empty = (count == '0);
      pop        = rd_en && !fifo_empty;
      push       = commit && (!fifo_full || pop);
      drop       = commit && fifo_full && !pop;
   end

   // Track the last captured pc and shift the history line on every capture
   always_ff @(posedge clk) begin
      if (reset) begin
         last_pc <= 32'd0;
         for (int i = 0; i <= DELAY; i++) begin
            hist_pc[i]   <= 32'd0;
            hist_inst[i] <= 32'd0;
         end
      end else if (capture) begin
         last_pc      <= pc;
         hist_pc[0]   <= pc;
         hist_inst[0] <= inst;
         for (int i = 1; i <= DELAY; i++) begin
            hist_pc[i]   <= hist_pc[i-1];
            hist_inst[i] <= hist_inst[i-1];
         end
      end
   end

   // Write accepted commit records into the FIFO storage
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_pc[i]   <= 32'd0;
            mem_inst[i] <= 32'd0;
         end
      end else if (push) begin
         mem_pc[wr_ptr]   <= retire_pc;
         mem_inst[wr_ptr] <= retire_inst;
      end
   end

   // Advance the FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Count commits, latch a dropped record as overflow, and stop at the commit limit
   always_ff @(posedge clk) begin
      if (reset) begin
         commit_count <= 16'd0;
         overflow     <= 1'b0;
         done         <= 1'b0;
      end else begin
         if (commit) begin
            commit_count <= commit_count + 16'd1;
            if (commit_count == LAST_COUNT) begin
               done <= 1'b1;
            end
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Present the FIFO head; outputs read as zero while nothing is queued
   always_comb begin
      rd_valid   = !fifo_empty;
      rd_pc      = 32'd0;
      rd_inst    = 32'd0;
      fifo_count = count;
      if (!fifo_empty) begin
         rd_pc   = mem_pc[rd_ptr];
         rd_inst = mem_inst[rd_ptr];
      end
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
// Self-checking bench for commit_trace_buffer: a fixed vector table for the
// basic alignment / stall / drain behaviour, hand sequences for overflow,
// the commit limit, mid-operation reset and the optional nop-skip build,
// then randomized traffic compared against a queue-based reference model.

module tb_commit_trace_buffer;

   localparam int DELAY = 4;
   localparam int DEPTH = 16;
   localparam int MAXC  = 24;
   localparam logic [31:0] KEY = 32'hA5A5A5A5;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [31:0]               pc;
   logic [31:0]               inst;
   logic                      cpu_stall;
   logic                      rd_en;
   logic                      rd_valid;
   logic [31:0]               rd_pc;
   logic [31:0]               rd_inst;
   logic [$clog2(DEPTH):0]    fifo_count;
   logic [15:0]               commit_count;
   logic                      overflow;
   logic                      done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rst;
      logic [31:0] pc;
      bit          stall;
      bit          rden;
      bit          expValid;
      logic [31:0] expPc;
      int          expCount;
      int          expCommit;
   } vec_t;

   vec_t vecs[17];

   // Reference model state: history as a queue (index 0 newest), FIFO as a queue
   logic [63:0] histQ[$];
   logic [63:0] fifoQ[$];
   logic [31:0] mLastPc;
   int          mCommits;
   bit          mOverflow;
   bit          mDone;

   // Free-running clock
   always #5 clk = ~clk;

   commit_trace_buffer #(
      .DELAY(DELAY),
      .FIFO_DEPTH(DEPTH),
      .MAX_COUNT(MAXC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pc(pc),
      .inst(inst),
      .cpu_stall(cpu_stall),
      .rd_en(rd_en),
      .rd_valid(rd_valid),
      .rd_pc(rd_pc),
      .rd_inst(rd_inst),
      .fifo_count(fifo_count),
      .commit_count(commit_count),
      .overflow(overflow),
      .done(done)
   );

   function automatic vec_t mk(bit r, logic [31:0] p, bit st, bit re,
                               bit ev, logic [31:0] ep, int ec, int ecm);
      vec_t v;
      v.rst = r; v.pc = p; v.stall = st; v.rden = re;
      v.expValid = ev; v.expPc = ep; v.expCount = ec; v.expCommit = ecm;
      return v;
   endfunction

   function void modelStep(bit r, logic [31:0] p, logic [31:0] i, bit st, bit re);
      logic [63:0] cand;
      bit          isCommit;
      if (r) begin
         histQ = {};
         for (int k = 0; k <= DELAY; k++) histQ.push_back(64'd0);
         fifoQ     = {};
         mLastPc   = 32'd0;
         mCommits  = 0;
         mOverflow = 1'b0;
         mDone     = 1'b0;
         return;
      end
      if (re && fifoQ.size() > 0) void'(fifoQ.pop_front());
      if (!st && !mDone && p != mLastPc) begin
         cand = histQ[DELAY-1];
         histQ.push_front({p, i});
         void'(histQ.pop_back());
         mLastPc = p;
         isCommit = (cand[63:32] != 32'd0);
`ifdef TRACE_SKIP_NOP_EN
         if (cand[31:0] == 32'd0) isCommit = 1'b0;
`endif
         if (isCommit) begin
            mCommits++;
            if (fifoQ.size() < DEPTH) fifoQ.push_back(cand);
            else mOverflow = 1'b1;
            if (mCommits == MAXC) mDone = 1'b1;
         end
      end
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit r, input logic [31:0] p, input logic [31:0] i,
                                input bit st, input bit re);
      reset     = r;
      pc        = p;
      inst      = i;
      cpu_stall = st;
      rd_en     = re;
      @(posedge clk);
      modelStep(r, p, i, st, re);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      bit          ev;
      logic [31:0] ep;
      logic [31:0] ei;
      ev = (fifoQ.size() != 0);
      ep = ev ? fifoQ[0][63:32] : 32'd0;
      ei = ev ? fifoQ[0][31:0]  : 32'd0;
      checkVal({tag, " rd_valid"},     32'(rd_valid),     32'(ev));
      checkVal({tag, " rd_pc"},        rd_pc,             ep);
      checkVal({tag, " rd_inst"},      rd_inst,           ei);
      checkVal({tag, " fifo_count"},   32'(fifo_count),   32'(fifoQ.size()));
      checkVal({tag, " commit_count"}, 32'(commit_count), 32'(mCommits));
      checkVal({tag, " overflow"},     32'(overflow),     32'(mOverflow));
      checkVal({tag, " done"},         32'(done),         32'(mDone));
   endtask

   // Hard time limit so the run always ends
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      logic [31:0] p;
      logic [31:0] i;
      bit          st, re, r;
      int          sel;

      vecs[0]  = mk(1, 32'h0,        0, 0, 0, 32'h0,        0, 0);
      vecs[1]  = mk(0, 32'h00400000, 0, 0, 0, 32'h0,        0, 0);
      vecs[2]  = mk(0, 32'h00400004, 0, 0, 0, 32'h0,        0, 0);
      vecs[3]  = mk(0, 32'h00400008, 0, 0, 0, 32'h0,        0, 0);
      vecs[4]  = mk(0, 32'h0040000C, 0, 0, 0, 32'h0,        0, 0);
      vecs[5]  = mk(0, 32'h00400010, 0, 0, 1, 32'h00400000, 1, 1);
      vecs[6]  = mk(0, 32'h00400014, 0, 0, 1, 32'h00400000, 2, 2);
      vecs[7]  = mk(0, 32'h00400014, 0, 0, 1, 32'h00400000, 2, 2);
      vecs[8]  = mk(0, 32'h00400014, 0, 0, 1, 32'h00400000, 2, 2);
      vecs[9]  = mk(0, 32'h00400014, 0, 0, 1, 32'h00400000, 2, 2);
      vecs[10] = mk(0, 32'h00400018, 1, 0, 1, 32'h00400000, 2, 2);
      vecs[11] = mk(0, 32'h0040001C, 1, 0, 1, 32'h00400000, 2, 2);
      vecs[12] = mk(0, 32'h0040001C, 0, 0, 1, 32'h00400000, 3, 3);
      vecs[13] = mk(0, 32'h0040001C, 0, 1, 1, 32'h00400004, 2, 3);
      vecs[14] = mk(0, 32'h0040001C, 0, 1, 1, 32'h00400008, 1, 3);
      vecs[15] = mk(0, 32'h0040001C, 0, 1, 0, 32'h0,        0, 3);
      vecs[16] = mk(0, 32'h0040001C, 0, 1, 0, 32'h0,        0, 3);

      modelStep(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);

      // Table-driven alignment, stall/repeat and drain vectors
      for (int n = 0; n < 17; n++) begin
         applyStimulus(vecs[n].rst, vecs[n].pc, vecs[n].pc ^ KEY, vecs[n].stall, vecs[n].rden);
         checkOutput($sformatf("vec%0d model", n));
         checkVal($sformatf("vec%0d rd_valid", n), 32'(rd_valid), 32'(vecs[n].expValid));
         checkVal($sformatf("vec%0d rd_pc", n), rd_pc, vecs[n].expPc);
         checkVal($sformatf("vec%0d rd_inst", n), rd_inst,
                  vecs[n].expValid ? (vecs[n].expPc ^ KEY) : 32'd0);
         checkVal($sformatf("vec%0d fifo_count", n), 32'(fifo_count), 32'(vecs[n].expCount));
         checkVal($sformatf("vec%0d commit_count", n), 32'(commit_count), 32'(vecs[n].expCommit));
      end

      // Overflow: 24 captures with no reader gives 20 commits into a 16-entry FIFO
      applyStimulus(1, 32'd0, 32'd0, 0, 0);
      for (int k = 0; k < 24; k++) begin
         p = 32'h00001000 + 32'(4 * k);
         applyStimulus(0, p, p ^ KEY, 0, 0);
         checkOutput("ovf");
      end
      checkVal("ovf fifo_count", 32'(fifo_count), 32'd16);
      checkVal("ovf overflow", 32'(overflow), 32'd1);
      checkVal("ovf commit_count", 32'(commit_count), 32'd20);
      checkVal("ovf head pc", rd_pc, 32'h00001000);
      checkVal("ovf head inst", rd_inst, 32'h00001000 ^ KEY);
      p = 32'h00001000 + 32'(4 * 24);
      applyStimulus(0, p, p ^ KEY, 0, 1);
      checkOutput("ovf pushpop");
      checkVal("full pushpop fifo_count", 32'(fifo_count), 32'd16);
      checkVal("full pushpop commit_count", 32'(commit_count), 32'd21);
      checkVal("full pushpop head pc", rd_pc, 32'h00001004);

      // Drain down to five entries, then reset mid-operation
      for (int k = 0; k < 11; k++) begin
         applyStimulus(0, p, p ^ KEY, 0, 1);
         checkOutput("predrain");
      end
      checkVal("prereset fifo_count", 32'(fifo_count), 32'd5);
      applyStimulus(1, p, p ^ KEY, 0, 0);
      checkOutput("midreset");
      checkVal("midreset rd_valid", 32'(rd_valid), 32'd0);
      checkVal("midreset fifo_count", 32'(fifo_count), 32'd0);
      checkVal("midreset commit_count", 32'(commit_count), 32'd0);
      checkVal("midreset overflow", 32'(overflow), 32'd0);
      for (int k = 0; k < 5; k++) begin
         p = 32'h00005000 + 32'(4 * k);
         applyStimulus(0, p, p ^ KEY, 0, 0);
         checkOutput("postreset");
         if (k == 3) checkVal("postreset 4th commit_count", 32'(commit_count), 32'd0);
      end
      checkVal("postreset 5th commit_count", 32'(commit_count), 32'd1);
      checkVal("postreset head pc", rd_pc, 32'h00005000);

      // Commit limit: done on the MAXC-th commit, then frozen
      applyStimulus(1, 32'd0, 32'd0, 0, 0);
      for (int k = 0; k < 35; k++) begin
         p = 32'h00002000 + 32'(4 * k);
         applyStimulus(0, p, p ^ KEY, 0, 0);
         checkOutput("limit");
         if (k == 26) begin
            checkVal("limit before done", 32'(done), 32'd0);
            checkVal("limit before count", 32'(commit_count), 32'(MAXC - 1));
         end
         if (k == 27) begin
            checkVal("limit done", 32'(done), 32'd1);
            checkVal("limit count", 32'(commit_count), 32'(MAXC));
         end
      end
      checkVal("limit frozen count", 32'(commit_count), 32'(MAXC));
      checkVal("limit frozen done", 32'(done), 32'd1);
      for (int k = 0; k < 16; k++) begin
         checkVal($sformatf("limit drain %0d pc", k), rd_pc, 32'h00002000 + 32'(4 * k));
         applyStimulus(0, p, p ^ KEY, 0, 1);
         checkOutput("limit drain");
      end
      checkVal("limit drained rd_valid", 32'(rd_valid), 32'd0);
      checkVal("limit drained done", 32'(done), 32'd1);

      // Zero instruction reaching the retire slot
      applyStimulus(1, 32'd0, 32'd0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         p = 32'h00004000 + 32'(4 * k);
         i = (k == 1) ? 32'd0 : (p ^ KEY);
         applyStimulus(0, p, i, 0, 0);
         checkOutput("nop");
      end
`ifdef TRACE_SKIP_NOP_EN
      checkVal("nop commit_count", 32'(commit_count), 32'd1);
      checkVal("nop fifo_count", 32'(fifo_count), 32'd1);
`else
      checkVal("nop commit_count", 32'(commit_count), 32'd2);
      checkVal("nop fifo_count", 32'(fifo_count), 32'd2);
`endif
      checkVal("nop head pc", rd_pc, 32'h00004000);

      // Randomized traffic against the reference model
      applyStimulus(1, 32'd0, 32'd0, 0, 0);
      p = 32'd0;
      for (int n = 0; n < 3000; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 2)      p = 32'd0;
         else if (sel < 4) p = p;
         else              p = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         i  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         st = ($urandom_range(0, 4) == 0);
         re = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 99) < 2);
         applyStimulus(r, p, i, st, re);
         checkOutput($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
